// File: rtl/mic_sample_capture.sv
// rtl/mic_sample_capture.sv - periodic SPI microphone sample capture with FWFT FIFO
//
// Purpose: generates mic CSB/SCK (SPI mode 0) once per sample period, shifts in
// SAMPLE_BITS MSB-first, and queues each completed sample in a first-word-fall-
// through FIFO that the CPU drains.
//
// Optional feature: define MIC_CAPTURE_IRQ_EN to enable the registered FIFO
// level interrupt; otherwise irq is tied low.
//
// Ports:
//   clk, resetn          system clock, asynchronous active-low reset
//   enable               capture enable (rising edge restarts the sample timer)
//   spi_csb/sck/sdo/sdi  mic SPI pins; sdo is held 0
//   rd_en, rd_data       FIFO pop strobe and head entry (0 when empty)
//   empty, full, count   FIFO status and occupancy
//   overrun, clr_overrun sticky lost-sample flag and its clear
//   irq                  FIFO level interrupt
module mic_sample_capture #(
  parameter int SAMPLE_BITS     = 16,
  parameter int CLK_DIV         = 4,
  parameter int SAMPLE_PERIOD   = 3125,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int IRQ_THRESH      = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       enable,
  output logic                       spi_csb,
  output logic                       spi_sck,
  output logic                       spi_sdo,
  input  logic                       spi_sdi,
  input  logic                       rd_en,
  output logic [SAMPLE_BITS-1:0]     rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [FIFO_DEPTH_LOG2:0]   count,
  output logic                       overrun,
  input  logic                       clr_overrun,
  output logic                       irq
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;
  localparam int TMR_W = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(SAMPLE_BITS + 1);

  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(SAMPLE_PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(SAMPLE_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);

  typedef enum logic [2:0] {IDLE, SETUP, SCK_LO, SCK_HI, HOLD} state_t;

  state_t                     state, state_next;
  logic                       enable_d;
  logic [TMR_W-1:0]           timer;
  logic [DIV_W-1:0]           div_cnt;
  logic [BIT_W-1:0]           bit_cnt;
  logic [SAMPLE_BITS-1:0]     shreg;
  logic                       en_rise, tick, phase_done;
  logic                       push, pop, push_ok, drop;
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [SAMPLE_BITS-1:0]     mem [DEPTH];
  logic [CNT_W-1:0]           count_r;
  logic                       overrun_r;

  // ---------------- sample timer ----------------
  assign en_rise = enable & ~enable_d;
  // The load cycle itself never ticks, so the first tick lands SAMPLE_PERIOD
  // cycles after the rising edge of enable.
  assign tick    = enable & ~en_rise & (timer == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      enable_d <= 1'b0;
      timer    <= '0;
    end else begin
      enable_d <= enable;
      if (!enable)
        timer <= '0;
      else if (en_rise || timer == '0)
        timer <= TMR_RELOAD;
      else
        timer <= timer - 1'b1;
    end
  end

  // ---------------- SPI sequencer ----------------
  assign phase_done = (div_cnt == DIV_LAST);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick)       state_next = SETUP;
      SETUP:   if (phase_done) state_next = SCK_LO;
      SCK_LO:  if (phase_done) state_next = SCK_HI;
      SCK_HI:  if (phase_done) state_next = (bit_cnt == BIT_LAST) ? HOLD : SCK_LO;
      HOLD:    if (phase_done) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
    // Dropping enable aborts any transaction on the next edge.
    if (!enable) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state || state == IDLE)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + 1'b1;
      if (state == IDLE)
        bit_cnt <= '0;
      else if (state == SCK_HI && phase_done)
        bit_cnt <= bit_cnt + 1'b1;
      // Sample on the edge that raises sck (mode 0).
      if (state == SCK_LO && state_next == SCK_HI)
        shreg <= {shreg[SAMPLE_BITS-2:0], spi_sdi};
    end
  end

  assign spi_csb = (state == IDLE);
  assign spi_sck = (state == SCK_HI);
  assign spi_sdo = 1'b0;

  // Push only when HOLD completes normally; an abort from HOLD leaves enable low.
  assign push = (state == HOLD) && (state_next == IDLE) && enable;

  // ---------------- FWFT FIFO ----------------
  assign empty   = (count_r == '0);
  assign full    = (count_r == CNT_FULL);
  assign pop     = rd_en & ~empty;
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];
  assign count   = count_r;

  // ---------------- overrun ----------------
  // A new loss event takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      overrun_r <= 1'b0;
    else if (drop || (tick && state != IDLE))
      overrun_r <= 1'b1;
    else if (clr_overrun)
      overrun_r <= 1'b0;
  end

  assign overrun = overrun_r;

`ifdef MIC_CAPTURE_IRQ_EN
  logic irq_r;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      irq_r <= 1'b0;
    else
      irq_r <= (count_r >= CNT_W'(IRQ_THRESH)) | overrun_r;
  end
  assign irq = irq_r;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_mic_sample_capture.sv
// tb/tb_mic_sample_capture.sv - self-checking bench for mic_sample_capture
module tb_mic_sample_capture;

`ifdef MIC_CAPTURE_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        spi_csb, spi_sck, spi_sdo;
  logic        spi_sdi = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] rd_data;
  logic        empty, full;
  logic [4:0]  count;
  logic        overrun;
  logic        clr_overrun = 1'b0;
  logic        irq;

  int n_vec = 0;
  int n_bad = 0;

  mic_sample_capture #(
    .SAMPLE_BITS(16), .CLK_DIV(2), .SAMPLE_PERIOD(200),
    .FIFO_DEPTH_LOG2(4), .IRQ_THRESH(8)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .spi_csb(spi_csb), .spi_sck(spi_sck), .spi_sdo(spi_sdo), .spi_sdi(spi_sdi),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .overrun(overrun), .clr_overrun(clr_overrun), .irq(irq)
  );

  always #5 clk = ~clk;

  // Mic model: MSB valid when csb falls, next bit after each sck fall.
  logic [15:0] mic_word = 16'h0000;
  logic        auto_inc = 1'b0;
  int          xfer_start = 0;
  int          xfer_cnt = 0;
  int          bit_idx = 0;
  logic        in_xfer = 1'b0;
  logic [15:0] cur_word = 16'h0000;
  int          sck_pulses = 0;

  always @(negedge spi_csb or posedge spi_csb or negedge spi_sck) begin
    if (spi_csb) begin
      in_xfer = 1'b0;
    end else if (!in_xfer) begin
      in_xfer  = 1'b1;
      cur_word = auto_inc ? mic_word + 16'(xfer_cnt - xfer_start) : mic_word;
      xfer_cnt = xfer_cnt + 1;
      bit_idx  = 15;
      spi_sdi  = cur_word[15];
    end else if (bit_idx > 0) begin
      bit_idx = bit_idx - 1;
      spi_sdi = cur_word[bit_idx];
    end
  end

  always @(posedge spi_sck) sck_pulses = sck_pulses + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_csb(input logic lvl, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (spi_csb === lvl) begin
        n = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic [15:0] rd_data;
    logic [4:0]  count;
    logic        empty;
    logic        full;
    logic        irq;
  } vec_t;

  vec_t tbl[17];
  int   n, n2, p0, tmo, low_seen;

  initial begin
    // Drain table for the 16-deep fill of 0x0001..0x0010. irq lags count by
    // one edge, so each row's irq reflects the previous row's count.
    for (int i = 0; i < 17; i++) begin
      tbl[i].rd_data = (i < 16) ? 16'(i + 1) : 16'h0000;
      tbl[i].count   = 5'(16 - i);
      tbl[i].empty   = (i == 16);
      tbl[i].full    = (i == 0);
      tbl[i].irq     = IRQ_ON & ((i == 0) ? 1'b1 : ((17 - i) >= 8));
    end

    // ---- reset values ----
    repeat (3) @(negedge clk);
    check("rst_csb", spi_csb, 1);
    check("rst_sck", spi_sck, 0);
    check("rst_sdo", spi_sdo, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_overrun", overrun, 0);
    check("rst_irq", irq, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // ---- single capture of 0xA55A ----
    mic_word = 16'hA55A;
    p0 = sck_pulses;
    enable = 1'b1;
    wait_csb(1'b0, 400, n);
    check("t1_csb_fall_edges", n, 201);
    wait_csb(1'b1, 200, n2);
    check("t1_csb_low_edges", n2, 68);
    check("t1_sck_pulses", sck_pulses - p0, 16);
    check("t1_rd_data", rd_data, 16'hA55A);
    check("t1_count", count, 1);
    check("t1_empty", empty, 0);
    check("t1_irq", irq, 0);
    enable = 1'b0;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("t1_pop_empty", empty, 1);
    check("t1_pop_rd_data", rd_data, 0);

    // ---- fill past full: 17 samples 0x0001.. with no reads ----
    mic_word = 16'h0001;
    xfer_start = xfer_cnt;
    auto_inc = 1'b1;
    enable = 1'b1;
    tmo = 0;
    for (int k = 0; k < 17; k++) begin
      wait_csb(1'b0, 400, n);
      if (n < 0) tmo++;
      wait_csb(1'b1, 200, n);
      if (n < 0) tmo++;
    end
    enable = 1'b0;
    auto_inc = 1'b0;
    check("t2_timeouts", tmo, 0);
    check("t2_count", count, 16);
    check("t2_full", full, 1);
    check("t2_overrun", overrun, 1);
    check("t2_irq", irq, IRQ_ON);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("t2_clr_overrun", overrun, 0);
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      check($sformatf("t2_drain%0d_rd_data", i), rd_data, tbl[i].rd_data);
      check($sformatf("t2_drain%0d_count", i), count, tbl[i].count);
      check($sformatf("t2_drain%0d_empty", i), empty, tbl[i].empty);
      check($sformatf("t2_drain%0d_full", i), full, tbl[i].full);
      check($sformatf("t2_drain%0d_irq", i), irq, tbl[i].irq);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
    check("t2_pop_while_empty_count", count, 0);
    check("t2_pop_while_empty_overrun", overrun, 0);

    // ---- full FIFO with pop on the push edge ----
    mic_word = 16'h0100;
    xfer_start = xfer_cnt;
    auto_inc = 1'b1;
    enable = 1'b1;
    tmo = 0;
    for (int k = 0; k < 16; k++) begin
      wait_csb(1'b0, 400, n);
      if (n < 0) tmo++;
      wait_csb(1'b1, 200, n);
      if (n < 0) tmo++;
    end
    check("t3_timeouts", tmo, 0);
    check("t3_full_before", full, 1);
    check("t3_overrun_before", overrun, 0);
    wait_csb(1'b0, 400, n);
    check("t3_17th_start", n > 0, 1);
    repeat (67) @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    enable = 1'b0;
    auto_inc = 1'b0;
    check("t3_csb_at_push", spi_csb, 1);
    check("t3_count", count, 16);
    check("t3_full", full, 1);
    check("t3_overrun", overrun, 0);
    check("t3_head", rd_data, 16'h0101);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t3_drain%0d", i), rd_data, 16'h0101 + 16'(i));
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
    check("t3_drained_empty", empty, 1);

    // ---- enable dropped mid-transaction ----
    mic_word = 16'h3C5A;
    @(negedge clk);
    enable = 1'b1;
    wait_csb(1'b0, 400, n);
    check("t4_csb_fall_edges", n, 201);
    p0 = sck_pulses;
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (sck_pulses - p0 == 7) begin
        n = i;
        break;
      end
    end
    check("t4_reach_bit7", n > 0, 1);
    enable = 1'b0;
    @(negedge clk);
    check("t4_abort_csb", spi_csb, 1);
    check("t4_abort_sck", spi_sck, 0);
    repeat (150) @(negedge clk);
    check("t4_abort_count", count, 0);
    enable = 1'b1;
    wait_csb(1'b0, 400, n);
    check("t4_reenable_edges", n, 201);
    wait_csb(1'b1, 200, n2);
    check("t4_low_edges", n2, 68);
    check("t4_rd_data", rd_data, 16'h3C5A);
    check("t4_count", count, 1);

    // ---- asynchronous reset mid SCK_HI with 3 queued ----
    for (int k = 0; k < 2; k++) begin
      wait_csb(1'b0, 400, n);
      wait_csb(1'b1, 200, n2);
    end
    check("t5_queued", count, 3);
    wait_csb(1'b0, 400, n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      if (spi_sck === 1'b1) begin
        n = i;
        break;
      end
      @(negedge clk);
    end
    check("t5_in_sck_hi", n > 0, 1);
    #2 resetn = 1'b0;
    #1;
    check("t5_rst_csb", spi_csb, 1);
    check("t5_rst_sck", spi_sck, 0);
    check("t5_rst_count", count, 0);
    check("t5_rst_empty", empty, 1);
    check("t5_rst_rd_data", rd_data, 0);
    check("t5_rst_irq", irq, 0);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    low_seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (spi_csb !== 1'b1) low_seen++;
    end
    check("t5_no_capture_disabled", low_seen, 0);
    enable = 1'b1;
    wait_csb(1'b0, 400, n);
    check("t5_restart_edges", n, 201);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
